// File: rtl/nvdla_dbb_burst_split_pkg.sv
// Shared types for the NVDLA burst to DBB single-beat splitter.
`ifndef NVDLA_PRIMARY_MEMIF_WIDTH
`define NVDLA_PRIMARY_MEMIF_WIDTH 512
`endif

package nvdla_package;

  localparam int unsigned NVDLA_ADDR_W = 32;
  localparam int unsigned NVDLA_DATA_W = `NVDLA_PRIMARY_MEMIF_WIDTH;
  localparam int unsigned NVDLA_STRB_W = NVDLA_DATA_W / 8;
  localparam int unsigned NVDLA_LEN_W  = 4;
  localparam int unsigned NVDLA_ID_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_DAT  = 3'd2,
    ST_WR_BRSP = 3'd3,
    ST_WR_RSP  = 3'd4,
    ST_RD_REQ  = 3'd5,
    ST_RD_DAT  = 3'd6
  } state_burst_fsm_t;

  typedef struct packed {
    logic                    wr_req_valid;
    logic [NVDLA_ADDR_W-1:0] wr_req_addr;
    logic [NVDLA_LEN_W-1:0]  wr_req_len;
    logic [NVDLA_ID_W-1:0]   wr_req_id;
    logic                    wr_dat_valid;
    logic [NVDLA_DATA_W-1:0] wr_dat_data;
    logic [NVDLA_STRB_W-1:0] wr_dat_strb;
    logic                    wr_rsp_ready;
    logic                    rd_req_valid;
    logic [NVDLA_ADDR_W-1:0] rd_req_addr;
    logic [NVDLA_LEN_W-1:0]  rd_req_len;
    logic [NVDLA_ID_W-1:0]   rd_req_id;
    logic                    rd_dat_ready;
  } nvdla_burst_in_t;

  typedef struct packed {
    logic                    wr_req_ready;
    logic                    wr_dat_ready;
    logic                    wr_rsp_valid;
    logic [NVDLA_ID_W-1:0]   wr_rsp_id;
    logic                    rd_req_ready;
    logic                    rd_dat_valid;
    logic [NVDLA_DATA_W-1:0] rd_dat_data;
    logic [NVDLA_ID_W-1:0]   rd_dat_id;
    logic                    rd_dat_last;
  } nvdla_burst_out_t;

  typedef struct packed {
    logic ready;
  } dbb_rdy_t;

  typedef struct packed {
    logic                    valid;
    logic [NVDLA_ADDR_W-1:0] addr;
    logic [NVDLA_ID_W-1:0]   id;
  } dbb_req_ctrl_t;

  typedef struct packed {
    logic                    valid;
    logic [NVDLA_DATA_W-1:0] data;
    logic [NVDLA_STRB_W-1:0] strb;
  } dbb_wdat_ctrl_t;

  typedef struct packed {
    logic                  valid;
    logic [NVDLA_ID_W-1:0] id;
  } dbb_rsp_flags_t;

  typedef struct packed {
    logic                    valid;
    logic [NVDLA_DATA_W-1:0] data;
    logic [NVDLA_ID_W-1:0]   id;
  } dbb_rdat_flags_t;

  typedef struct packed {
    dbb_req_ctrl_t  write_request_ctrl;
    dbb_wdat_ctrl_t write_data_ctrl;
    dbb_rdy_t       write_response_ctrl;
    dbb_req_ctrl_t  read_request_ctrl;
    dbb_rdy_t       read_data_ctrl;
  } ctrl_dbb_t;

  typedef struct packed {
    dbb_rdy_t        write_request_flags;
    dbb_rdy_t        write_data_flags;
    dbb_rsp_flags_t  write_response_flags;
    dbb_rdy_t        read_request_flags;
    dbb_rdat_flags_t read_data_flags;
  } flags_dbb_t;

endpackage

// File: rtl/nvdla_dbb_burst_split_if.sv
// Bundles the NVDLA-side and DBB-side buses of the burst splitter.
interface nvdla_dbb_burst_split_if;
  import nvdla_package::*;

  nvdla_burst_in_t  nvdla_i;
  nvdla_burst_out_t nvdla_o;
  ctrl_dbb_t        dbb_ctrl_o;
  flags_dbb_t       dbb_flags_i;

  // Splitter side: consumes NVDLA bursts and DBB flags.
  modport slave (
    input  nvdla_i,
    input  dbb_flags_i,
    output nvdla_o,
    output dbb_ctrl_o
  );

  // Environment side: drives NVDLA bursts and DBB flags.
  modport master (
    output nvdla_i,
    output dbb_flags_i,
    input  nvdla_o,
    input  dbb_ctrl_o
  );

endinterface

// File: rtl/nvdla_dbb_burst_split.sv
// Splits NVDLA bursts into single-beat DBB transactions, one burst in flight.
`ifndef NVDLA_PRIMARY_MEMIF_WIDTH
`define NVDLA_PRIMARY_MEMIF_WIDTH 512
`endif

module nvdla_dbb_burst_split
  import nvdla_package::*;
#(
  parameter int unsigned BEAT_BYTES = `NVDLA_PRIMARY_MEMIF_WIDTH / 8,
  parameter int unsigned LEN_W      = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  nvdla_dbb_burst_split_if.slave bus
);

  state_burst_fsm_t        r_state;
  logic [LEN_W-1:0]        r_beat_cnt;
  logic [LEN_W-1:0]        r_len;
  logic [NVDLA_ADDR_W-1:0] r_cur_addr;
  logic [NVDLA_ID_W-1:0]   r_id;

  state_burst_fsm_t        w_state_nxt;
  logic [LEN_W-1:0]        w_beat_cnt_nxt;
  logic [LEN_W-1:0]        w_len_nxt;
  logic [NVDLA_ADDR_W-1:0] w_cur_addr_nxt;
  logic [NVDLA_ID_W-1:0]   w_id_nxt;
  logic                    w_last;
  nvdla_burst_out_t        w_nvdla_o;
  ctrl_dbb_t               w_dbb_ctrl_o;
  logic                    w_unused;

  // Response/read-data IDs from the bridge are not checked.
  assign w_unused = ^{bus.dbb_flags_i.write_response_flags.id,
                      bus.dbb_flags_i.read_data_flags.id,
                      bus.nvdla_i.wr_req_len, bus.nvdla_i.rd_req_len};

  assign w_last = (r_beat_cnt == r_len);

  // State and burst context registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_len      <= '0;
      r_cur_addr <= '0;
      r_id       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_len      <= w_len_nxt;
      r_cur_addr <= w_cur_addr_nxt;
      r_id       <= w_id_nxt;
    end
  end

  // Next-state and output decode; handshakes act on the following cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_len_nxt      = r_len;
    w_cur_addr_nxt = r_cur_addr;
    w_id_nxt       = r_id;
    w_nvdla_o      = '0;
    w_dbb_ctrl_o   = '0;

    w_dbb_ctrl_o.write_request_ctrl.addr = r_cur_addr;
    w_dbb_ctrl_o.write_request_ctrl.id   = r_id;
    w_dbb_ctrl_o.write_data_ctrl.data    = bus.nvdla_i.wr_dat_data;
    w_dbb_ctrl_o.write_data_ctrl.strb    = bus.nvdla_i.wr_dat_strb;
    w_dbb_ctrl_o.read_request_ctrl.addr  = r_cur_addr;
    w_dbb_ctrl_o.read_request_ctrl.id    = r_id;
    w_nvdla_o.wr_rsp_id                  = r_id;
    w_nvdla_o.rd_dat_data                = bus.dbb_flags_i.read_data_flags.data;
    w_nvdla_o.rd_dat_id                  = r_id;

    unique case (r_state)
      ST_IDLE: begin
        w_nvdla_o.wr_req_ready = 1'b1;
        w_nvdla_o.rd_req_ready = !bus.nvdla_i.wr_req_valid;
        if (bus.nvdla_i.wr_req_valid) begin
          w_cur_addr_nxt = bus.nvdla_i.wr_req_addr;
          w_len_nxt      = LEN_W'(bus.nvdla_i.wr_req_len);
          w_id_nxt       = bus.nvdla_i.wr_req_id;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_WR_REQ;
        end else if (bus.nvdla_i.rd_req_valid) begin
          w_cur_addr_nxt = bus.nvdla_i.rd_req_addr;
          w_len_nxt      = LEN_W'(bus.nvdla_i.rd_req_len);
          w_id_nxt       = bus.nvdla_i.rd_req_id;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        w_dbb_ctrl_o.write_request_ctrl.valid = 1'b1;
        if (bus.dbb_flags_i.write_request_flags.ready) w_state_nxt = ST_WR_DAT;
      end
      ST_WR_DAT: begin
        w_dbb_ctrl_o.write_data_ctrl.valid = bus.nvdla_i.wr_dat_valid;
        w_nvdla_o.wr_dat_ready             = bus.dbb_flags_i.write_data_flags.ready;
        if (bus.nvdla_i.wr_dat_valid && bus.dbb_flags_i.write_data_flags.ready)
          w_state_nxt = ST_WR_BRSP;
      end
      ST_WR_BRSP: begin
        w_dbb_ctrl_o.write_response_ctrl.ready = 1'b1;
        if (bus.dbb_flags_i.write_response_flags.valid) begin
          if (w_last) begin
            w_state_nxt = ST_WR_RSP;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + LEN_W'(1);
            w_cur_addr_nxt = r_cur_addr + NVDLA_ADDR_W'(BEAT_BYTES);
            w_state_nxt    = ST_WR_REQ;
          end
        end
      end
      ST_WR_RSP: begin
        w_nvdla_o.wr_rsp_valid = 1'b1;
        if (bus.nvdla_i.wr_rsp_ready) w_state_nxt = ST_IDLE;
      end
      ST_RD_REQ: begin
        w_dbb_ctrl_o.read_request_ctrl.valid = 1'b1;
        if (bus.dbb_flags_i.read_request_flags.ready) w_state_nxt = ST_RD_DAT;
      end
      ST_RD_DAT: begin
        w_nvdla_o.rd_dat_valid            = bus.dbb_flags_i.read_data_flags.valid;
        w_nvdla_o.rd_dat_last             = w_last;
        w_dbb_ctrl_o.read_data_ctrl.ready = bus.nvdla_i.rd_dat_ready;
        if (bus.dbb_flags_i.read_data_flags.valid && bus.nvdla_i.rd_dat_ready) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + LEN_W'(1);
            w_cur_addr_nxt = r_cur_addr + NVDLA_ADDR_W'(BEAT_BYTES);
            w_state_nxt    = ST_RD_REQ;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Nothing handshakes while reset is held, not even the IDLE readies.
    if (rst_i) begin
      w_nvdla_o    = '0;
      w_dbb_ctrl_o = '0;
    end
  end

  assign bus.nvdla_o    = w_nvdla_o;
  assign bus.dbb_ctrl_o = w_dbb_ctrl_o;

endmodule

// File: tb/tb_nvdla_dbb_burst_split.sv
// Randomized directed bench for nvdla_dbb_burst_split with an address/beat model.
module tb_nvdla_dbb_burst_split;
  import nvdla_package::*;

  localparam int unsigned BEAT        = 64;
  localparam int unsigned FORCE_AFTER = 12;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  nvdla_dbb_burst_split_if bus_if ();

  nvdla_dbb_burst_split #(
    .BEAT_BYTES(BEAT),
    .LEN_W     (4)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // Reference: beat k of a burst lives at base + k*BEAT, modulo 2^32.
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int unsigned beat);
    logic [63:0] a;
    a = 64'(base) + 64'(beat) * 64'(BEAT);
    return a[31:0];
  endfunction

  function automatic logic [511:0] rnd_wide();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    logic [9:0] v;
    v = {bus_if.nvdla_o.wr_req_ready, bus_if.nvdla_o.wr_dat_ready,
         bus_if.nvdla_o.wr_rsp_valid, bus_if.nvdla_o.rd_req_ready,
         bus_if.nvdla_o.rd_dat_valid,
         bus_if.dbb_ctrl_o.write_request_ctrl.valid, bus_if.dbb_ctrl_o.write_data_ctrl.valid,
         bus_if.dbb_ctrl_o.write_response_ctrl.ready, bus_if.dbb_ctrl_o.read_request_ctrl.valid,
         bus_if.dbb_ctrl_o.read_data_ctrl.ready};
    chk32(tag, 32'(v), 32'd0);
  endtask

  task automatic clear_inputs();
    bus_if.nvdla_i     = '0;
    bus_if.dbb_flags_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic coin(input int unsigned pct, input int unsigned tries);
    return (tries >= FORCE_AFTER) || ($urandom_range(1, 100) <= pct);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id,
                          input int unsigned pct, input int abort_beat);
    logic hs, v, r;
    int unsigned tries;
    logic [511:0] d;
    logic [63:0] s;
    bus_if.nvdla_i.wr_req_valid = 1'b1;
    bus_if.nvdla_i.wr_req_addr  = addr;
    bus_if.nvdla_i.wr_req_len   = len;
    bus_if.nvdla_i.wr_req_id    = id;
    @(negedge clk);
    chk1("idle_wr_req_ready", bus_if.nvdla_o.wr_req_ready, 1'b1);
    chk1("idle_rd_req_ready_blocked", bus_if.nvdla_o.rd_req_ready, 1'b0);
    next_cycle();
    bus_if.nvdla_i.wr_req_valid = 1'b0;
    bus_if.nvdla_i.wr_req_addr  = $urandom;
    bus_if.nvdla_i.wr_req_id    = 8'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      tries = 0; hs = 1'b0;
      while (!hs) begin
        hs = coin(pct, tries);
        bus_if.dbb_flags_i.write_request_flags.ready  = hs;
        bus_if.dbb_flags_i.write_response_flags.valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk1($sformatf("wreq_valid b%0d", i), bus_if.dbb_ctrl_o.write_request_ctrl.valid, 1'b1);
        chk32($sformatf("wreq_addr b%0d", i), bus_if.dbb_ctrl_o.write_request_ctrl.addr,
              exp_addr(addr, 32'(i)));
        chk32($sformatf("wreq_id b%0d", i), 32'(bus_if.dbb_ctrl_o.write_request_ctrl.id), 32'(id));
        chk1("stray_rsp_ready", bus_if.dbb_ctrl_o.write_response_ctrl.ready, 1'b0);
        chk1("wr_rsp_early", bus_if.nvdla_o.wr_rsp_valid, 1'b0);
        chk1("rd_req_ready_busy", bus_if.nvdla_o.rd_req_ready, 1'b0);
        next_cycle();
        tries++;
      end
      bus_if.dbb_flags_i.write_request_flags.ready  = 1'b0;
      bus_if.dbb_flags_i.write_response_flags.valid = 1'b0;
      if (i == abort_beat) begin
        bus_if.nvdla_i.wr_dat_valid = 1'b1;
        @(negedge clk);
        chk1("pre_abort_wdat_valid", bus_if.dbb_ctrl_o.write_data_ctrl.valid, 1'b1);
        bus_if.nvdla_i.wr_req_valid = 1'b1;
        bus_if.nvdla_i.rd_req_valid = 1'b1;
        bus_if.nvdla_i.wr_rsp_ready = 1'b1;
        bus_if.nvdla_i.rd_dat_ready = 1'b1;
        bus_if.dbb_flags_i.write_request_flags.ready  = 1'b1;
        bus_if.dbb_flags_i.write_data_flags.ready     = 1'b1;
        bus_if.dbb_flags_i.write_response_flags.valid = 1'b1;
        bus_if.dbb_flags_i.read_request_flags.ready   = 1'b1;
        bus_if.dbb_flags_i.read_data_flags.valid      = 1'b1;
        rst = 1'b1;
        #1;
        chk_quiet("abort_reset_quiet");
        repeat (3) begin
          @(negedge clk);
          chk_quiet("abort_reset_held");
        end
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        chk1("post_abort_idle", bus_if.nvdla_o.wr_req_ready, 1'b1);
        chk1("post_abort_no_rsp", bus_if.nvdla_o.wr_rsp_valid, 1'b0);
        chk1("post_abort_no_wreq", bus_if.dbb_ctrl_o.write_request_ctrl.valid, 1'b0);
        next_cycle();
        return;
      end
      d = rnd_wide();
      s = {$urandom, $urandom};
      bus_if.nvdla_i.wr_dat_data = d;
      bus_if.nvdla_i.wr_dat_strb = s;
      tries = 0; hs = 1'b0;
      while (!hs) begin
        v = coin(pct, tries);
        r = coin(pct, tries);
        bus_if.nvdla_i.wr_dat_valid               = v;
        bus_if.dbb_flags_i.write_data_flags.ready = r;
        @(negedge clk);
        chk1($sformatf("wdat_valid b%0d", i), bus_if.dbb_ctrl_o.write_data_ctrl.valid, v);
        chk512($sformatf("wdat_data b%0d", i), bus_if.dbb_ctrl_o.write_data_ctrl.data, d);
        chk512($sformatf("wdat_strb b%0d", i), 512'(bus_if.dbb_ctrl_o.write_data_ctrl.strb), 512'(s));
        chk1($sformatf("wdat_ready b%0d", i), bus_if.nvdla_o.wr_dat_ready, r);
        hs = v && r;
        next_cycle();
        tries++;
      end
      bus_if.nvdla_i.wr_dat_valid               = 1'b0;
      bus_if.dbb_flags_i.write_data_flags.ready = 1'b0;
      tries = 0; hs = 1'b0;
      while (!hs) begin
        hs = coin(pct, tries);
        bus_if.dbb_flags_i.write_response_flags.valid = hs;
        bus_if.dbb_flags_i.write_response_flags.id    = 8'($urandom);
        @(negedge clk);
        chk1($sformatf("brsp_ready b%0d", i), bus_if.dbb_ctrl_o.write_response_ctrl.ready, 1'b1);
        chk1($sformatf("brsp_no_rsp b%0d", i), bus_if.nvdla_o.wr_rsp_valid, 1'b0);
        next_cycle();
        tries++;
      end
      bus_if.dbb_flags_i.write_response_flags.valid = 1'b0;
    end
    tries = 0; hs = 1'b0;
    while (!hs) begin
      hs = coin(pct, tries);
      bus_if.nvdla_i.wr_rsp_ready = hs;
      @(negedge clk);
      chk1("wr_rsp_valid", bus_if.nvdla_o.wr_rsp_valid, 1'b1);
      chk32("wr_rsp_id", 32'(bus_if.nvdla_o.wr_rsp_id), 32'(id));
      next_cycle();
      tries++;
    end
    bus_if.nvdla_i.wr_rsp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id,
                         input int unsigned pct, input int unsigned stall);
    logic hs, v, r;
    int unsigned tries;
    logic [511:0] d;
    bus_if.nvdla_i.rd_req_valid = 1'b1;
    bus_if.nvdla_i.rd_req_addr  = addr;
    bus_if.nvdla_i.rd_req_len   = len;
    bus_if.nvdla_i.rd_req_id    = id;
    @(negedge clk);
    chk1("idle_rd_req_ready", bus_if.nvdla_o.rd_req_ready, 1'b1);
    next_cycle();
    bus_if.nvdla_i.rd_req_valid = 1'b0;
    bus_if.nvdla_i.rd_req_addr  = $urandom;
    bus_if.nvdla_i.rd_req_id    = 8'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      tries = 0; hs = 1'b0;
      while (!hs) begin
        hs = coin(pct, tries);
        bus_if.dbb_flags_i.read_request_flags.ready = hs;
        bus_if.dbb_flags_i.read_data_flags.valid    = 1'($urandom_range(0, 1));
        bus_if.nvdla_i.rd_dat_ready                 = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk1($sformatf("rreq_valid b%0d", i), bus_if.dbb_ctrl_o.read_request_ctrl.valid, 1'b1);
        chk32($sformatf("rreq_addr b%0d", i), bus_if.dbb_ctrl_o.read_request_ctrl.addr,
              exp_addr(addr, 32'(i)));
        chk1("rreq_no_rdat", bus_if.nvdla_o.rd_dat_valid, 1'b0);
        chk1("rreq_no_rdy", bus_if.dbb_ctrl_o.read_data_ctrl.ready, 1'b0);
        chk1("rreq_wr_blocked", bus_if.nvdla_o.wr_req_ready, 1'b0);
        next_cycle();
        tries++;
      end
      bus_if.dbb_flags_i.read_request_flags.ready = 1'b0;
      d = rnd_wide();
      bus_if.dbb_flags_i.read_data_flags.data = d;
      bus_if.dbb_flags_i.read_data_flags.id   = 8'($urandom);
      v = (i == 0) && (stall > 0);
      tries = 0; hs = 1'b0;
      while (!hs) begin
        v = v || coin(pct, tries);
        if (i == 0 && tries < stall) r = 1'b0;
        else r = coin(pct, tries > stall ? tries - stall : 0);
        bus_if.dbb_flags_i.read_data_flags.valid = v;
        bus_if.nvdla_i.rd_dat_ready              = r;
        @(negedge clk);
        chk1($sformatf("rdat_valid b%0d", i), bus_if.nvdla_o.rd_dat_valid, v);
        chk1($sformatf("rdat_dbb_ready b%0d", i), bus_if.dbb_ctrl_o.read_data_ctrl.ready, r);
        if (v) begin
          chk512($sformatf("rdat_data b%0d", i), bus_if.nvdla_o.rd_dat_data, d);
          chk32($sformatf("rdat_id b%0d", i), 32'(bus_if.nvdla_o.rd_dat_id), 32'(id));
          chk1($sformatf("rdat_last b%0d", i), bus_if.nvdla_o.rd_dat_last, i == int'(len));
        end
        hs = v && r;
        next_cycle();
        tries++;
      end
      bus_if.dbb_flags_i.read_data_flags.valid = 1'b0;
      bus_if.nvdla_i.rd_dat_ready              = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  l;
    logic [7:0]  id;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus_if.nvdla_i.wr_req_valid = 1'b1;
    bus_if.nvdla_i.wr_dat_valid = 1'b1;
    bus_if.dbb_flags_i.write_data_flags.ready = 1'b1;
    bus_if.dbb_flags_i.read_data_flags.valid  = 1'b1;
    @(negedge clk);
    chk_quiet("reset_quiet");
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_idle_wr_ready", bus_if.nvdla_o.wr_req_ready, 1'b1);
    chk1("rst_idle_rd_ready", bus_if.nvdla_o.rd_req_ready, 1'b1);
    chk1("rst_idle_no_wreq", bus_if.dbb_ctrl_o.write_request_ctrl.valid, 1'b0);
    chk1("rst_idle_no_rreq", bus_if.dbb_ctrl_o.read_request_ctrl.valid, 1'b0);
    next_cycle();

    do_write(32'h0000_1000, 4'd3, 8'd5, 100, -1);
    do_read(32'h0000_2000, 4'd1, 8'd9, 100, 0);

    // Simultaneous requests: write first, read held until write response.
    bus_if.nvdla_i.rd_req_valid = 1'b1;
    bus_if.nvdla_i.rd_req_addr  = 32'h0000_3000;
    bus_if.nvdla_i.rd_req_len   = 4'd2;
    bus_if.nvdla_i.rd_req_id    = 8'd3;
    do_write(32'h0000_4000, 4'd2, 8'd7, 70, -1);
    do_read(32'h0000_3000, 4'd2, 8'd3, 70, 0);

    do_read(32'h0000_5000, 4'd2, 8'd4, 100, 5);
    do_write(32'hFFFF_FFC0, 4'd1, 8'd2, 100, -1);

    do_write(32'h0000_6000, 4'd3, 8'd8, 100, 2);
    do_write(32'h0000_7000, 4'd2, 8'd1, 80, -1);

    for (int k = 0; k < 16; k++) begin
      a  = $urandom;
      l  = 4'($urandom_range(0, 15));
      id = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk1("gap_idle", bus_if.nvdla_o.wr_req_ready, 1'b1);
        next_cycle();
      end
      if ($urandom_range(0, 1) == 1) do_write(a, l, id, $urandom_range(40, 100), -1);
      else do_read(a, l, id, $urandom_range(40, 100), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
